// File: rtl/fc_pkg.sv
// fc_pkg: constants and helpers shared by the FC output path and FC controller.
//   LANES           - byte lanes per output stream word
//   INT8_MAX/MIN    - requantization saturation limits
//   keep_mask()     - byte-count to keep-mask lookup
//   out_state_t     - output register state
package fc_pkg;

    localparam int unsigned LANES    = 4;
    localparam int          INT8_MAX = 127;
    localparam int          INT8_MIN = -128;

    typedef enum logic {
        IDLE_OUT,
        HOLD_OUT
    } out_state_t;

    // Ones in lanes 0..nbytes-1.
    function automatic logic [LANES-1:0] keep_mask(input logic [2:0] nbytes);
        logic [LANES-1:0] m;
        case (nbytes)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            3'd4:    m = 4'b1111;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// fc_requant: combinational requantization of one FC accumulator to int8.
//   acc     - signed accumulator (bias included)
//   relu_en - clamp negative results to zero
//   q8      - saturated int8 result
module fc_requant
    import fc_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int SHIFT     = 8
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic                        relu_en,
    output logic        [7:0]           q8
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(INT8_MAX);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(INT8_MIN);

    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] rectified;

    always_comb begin
        shifted   = acc >>> SHIFT;
        rectified = (relu_en && shifted[ACC_WIDTH-1]) ? '0 : shifted;
        if (rectified > SAT_HI) begin
            q8 = SAT_HI[7:0];
        end else if (rectified < SAT_LO) begin
            q8 = SAT_LO[7:0];
        end else begin
            q8 = rectified[7:0];
        end
    end

endmodule

// File: rtl/fc_output_packer.sv
// fc_output_packer: requantizes FC accumulator beats to int8 and packs them
// four per word onto an AXI4-Stream master. A vector of NUM_NEURONS results
// ends with a possibly short word flagged by m_axis_last.
//   axi_clk, axi_reset_n            - clock, async active-low reset
//   in_valid, in_data, in_ready     - accumulator input handshake
//   relu_en                         - ReLU enable, sampled per beat
//   m_axis_valid/data/ready/last/keep - packed int8 output stream
module fc_output_packer
    import fc_pkg::*;
#(
    parameter int AXI_BUS_WIDTH = 32,
    parameter int ACC_WIDTH     = 32,
    parameter int NUM_NEURONS   = 10,
    parameter int SHIFT         = 8
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    input  logic                     in_valid,
    input  logic [ACC_WIDTH-1:0]     in_data,
    output logic                     in_ready,
    input  logic                     relu_en,
    output logic                     m_axis_valid,
    output logic [AXI_BUS_WIDTH-1:0] m_axis_data,
    input  logic                     m_axis_ready,
    output logic                     m_axis_last,
    output logic [3:0]               m_axis_keep
);

    localparam int              NW          = 12;
    localparam logic [NW-1:0]   LAST_NEURON = NW'(NUM_NEURONS - 1);

    logic [1:0]               lane_cnt;
    logic [NW-1:0]            neuron_cnt;
    logic [AXI_BUS_WIDTH-1:0] pack_q;
    logic [AXI_BUS_WIDTH-1:0] out_data_q;
    logic [3:0]               out_keep_q;
    logic                     out_last_q;
    logic                     ready_en_q;
    out_state_t               state_q;
    out_state_t               state_d;

    logic [7:0]               q8;
    logic                     last_beat;
    logic                     closing;
    logic                     accept;
    logic                     load;
    logic [AXI_BUS_WIDTH-1:0] word_d;

    fc_requant #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT)
    ) u_requant (
        .acc     (in_data),
        .relu_en (relu_en),
        .q8      (q8)
    );

    assign last_beat = (neuron_cnt == LAST_NEURON);
    assign closing   = (lane_cnt == 2'd3) || last_beat;
    // ready_en_q holds in_ready low through reset and for no longer.
    assign in_ready  = ready_en_q && !(closing && m_axis_valid && !m_axis_ready);
    assign accept    = in_valid && in_ready;
    assign load      = accept && closing;

    // Pack register lanes above the current one are always zero, so a
    // closing word carries zeros in its unused lanes.
    always_comb begin
        word_d                        = pack_q;
        word_d[{lane_cnt, 3'b000} +: 8] = q8;
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            ready_en_q <= 1'b0;
            lane_cnt   <= '0;
            neuron_cnt <= '0;
            pack_q     <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (accept) begin
                if (closing) begin
                    lane_cnt <= '0;
                    pack_q   <= '0;
                end else begin
                    lane_cnt <= lane_cnt + 2'd1;
                    pack_q   <= word_d;
                end
                neuron_cnt <= last_beat ? '0 : neuron_cnt + NW'(1);
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
        end else if (load) begin
            out_data_q <= word_d;
            out_keep_q <= keep_mask({1'b0, lane_cnt} + 3'd1);
            out_last_q <= last_beat;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state_q <= IDLE_OUT;
        end else begin
            state_q <= state_d;
        end
    end

    // A load while holding is only possible when the held word drains in the
    // same cycle, so the output stays valid without a bubble.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_OUT: if (load) state_d = HOLD_OUT;
            HOLD_OUT: if (!load && m_axis_ready) state_d = IDLE_OUT;
            default:  state_d = IDLE_OUT;
        endcase
    end

    always_comb begin
        m_axis_valid = (state_q == HOLD_OUT);
        m_axis_data  = out_data_q;
        m_axis_keep  = out_keep_q;
        m_axis_last  = out_last_q;
    end

endmodule

// File: tb/tb_fc_output_packer.sv
module tb_fc_output_packer;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;
    typedef word_t wq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        relu_en;
    logic        mr;

    logic        rdy10, v10, l10;  logic [31:0] d10;  logic [3:0] k10;
    logic        rdy4,  v4,  l4;   logic [31:0] d4;   logic [3:0] k4;
    logic        rdy1,  v1,  l1;   logic [31:0] d1;   logic [3:0] k1;

    int total = 0;
    int bad   = 0;

    wq_t q10, q4, q1;
    bq_t bytes10;
    int  cyc = 0;
    int  hold_viol = 0;
    bit  stall_prev = 0;
    word_t hold_w;
    int  first1 = -1, last1 = -1, nv1 = 0;
    bit  rnd_mr = 0;

    always #5 clk = ~clk;

    fc_output_packer #(.AXI_BUS_WIDTH(32), .ACC_WIDTH(32), .NUM_NEURONS(10), .SHIFT(8)) u_dut10 (
        .axi_clk(clk), .axi_reset_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy10), .relu_en(relu_en), .m_axis_valid(v10), .m_axis_data(d10),
        .m_axis_ready(mr), .m_axis_last(l10), .m_axis_keep(k10));

    fc_output_packer #(.AXI_BUS_WIDTH(32), .ACC_WIDTH(32), .NUM_NEURONS(4), .SHIFT(8)) u_dut4 (
        .axi_clk(clk), .axi_reset_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy4), .relu_en(relu_en), .m_axis_valid(v4), .m_axis_data(d4),
        .m_axis_ready(mr), .m_axis_last(l4), .m_axis_keep(k4));

    fc_output_packer #(.AXI_BUS_WIDTH(32), .ACC_WIDTH(32), .NUM_NEURONS(1), .SHIFT(8)) u_dut1 (
        .axi_clk(clk), .axi_reset_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .relu_en(relu_en), .m_axis_valid(v1), .m_axis_data(d1),
        .m_axis_ready(mr), .m_axis_last(l1), .m_axis_keep(k1));

    // Output monitor: inputs change just after posedge, so the negedge view
    // is what the next posedge will act on.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (v10 && mr) q10.push_back({d10, k10, l10});
            if (v4 && mr)  q4.push_back({d4, k4, l4});
            if (v1 && mr)  q1.push_back({d1, k1, l1});
            if (stall_prev && ({v10, d10, k10, l10} !== {1'b1, hold_w})) hold_viol++;
            stall_prev = v10 && !mr;
            hold_w     = {d10, k10, l10};
            if (v1) begin
                if (first1 < 0) first1 = cyc;
                last1 = cyc;
                nv1++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_mr) mr = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Floor(x / 2^8), optional ReLU, clamp to int8.
    function automatic logic [7:0] ref_q(input logic signed [31:0] x, input bit relu);
        longint v = x;
        longint q = v / 256;
        if ((v % 256 != 0) && (v < 0)) q = q - 1;
        if (relu && q < 0) q = 0;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    // Expected words for a byte stream that starts at neuron 0 of a vector.
    function automatic wq_t model_words(input int n, input bq_t b);
        wq_t w;
        int  i = 0;
        while (i < b.size()) begin
            int    p = i % n;
            int    k = (n - p < 4) ? n - p : 4;
            word_t x;
            if (i + k > b.size()) break;
            x = '0;
            for (int j = 0; j < k; j++) x.d[8*j +: 8] = b[i+j];
            x.k = 4'((1 << k) - 1);
            x.l = (p + k == n);
            w.push_back(x);
            i += k;
        end
        return w;
    endfunction

    task automatic cmp_words(input string tag, input wq_t got, input wq_t exp);
        chk({tag, ".count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            chk($sformatf("%s.w%0d.data", tag, i), got[i].d, exp[i].d);
            chk($sformatf("%s.w%0d.keep", tag, i), 32'(got[i].k), 32'(exp[i].k));
            chk($sformatf("%s.w%0d.last", tag, i), 32'(got[i].l), 32'(exp[i].l));
        end
    endtask

    function automatic logic [31:0] rand_acc();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 2))
            0:       return r;
            1:       return {{16{r[15]}}, r[15:0]};
            default: return {{20{r[11]}}, r[11:0]};
        endcase
    endfunction

    task automatic send(input logic [31:0] x, input bit relu);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = x;
        relu_en  = relu;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rdy10) begin ok = 1; break; end
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        else     bytes10.push_back(ref_q(x, relu));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        q10.delete(); q4.delete(); q1.delete(); bytes10.delete();
        first1 = -1; last1 = -1; nv1 = 0;
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] x;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; relu_en = 1'b0; mr = 1'b1;

        // Reset state
        #3;
        chk("rst.valid", 32'(v10), 32'd0);
        chk("rst.data",  d10, 32'd0);
        chk("rst.keep",  32'(k10), 32'd0);
        chk("rst.last",  32'(l10), 32'd0);
        chk("rst.in_ready", 32'(rdy10), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.in_ready_after", 32'(rdy10), 32'd1);

        // Basic packing, NUM_NEURONS=4 (and NUM_NEURONS=1 in parallel)
        do_reset();
        for (int i = 1; i <= 4; i++) send(32'(i * 256), 1'b0);
        chk("basic.latency", 32'(v4), 32'd1);
        drain();
        chk("basic.count", q4.size(), 32'd1);
        if (q4.size() > 0) begin
            chk("basic.data", q4[0].d, 32'h04030201);
            chk("basic.keep", 32'(q4[0].k), 32'hF);
            chk("basic.last", 32'(q4[0].l), 32'd1);
        end
        cmp_words("n1", q1, model_words(1, bytes10));

        // Saturation with and without ReLU
        do_reset();
        send(32'h007FFF00, 1'b0);
        send(-32'sh007FFF00, 1'b0);
        send(32'h007FFF00, 1'b1);
        send(-32'sh007FFF00, 1'b1);
        drain();
        chk("sat.count", q4.size(), 32'd1);
        if (q4.size() > 0) chk("sat.data", q4[0].d, 32'h007F807F);

        // Short tail, NUM_NEURONS=10
        do_reset();
        for (int i = 0; i < 10; i++) send(32'h500, 1'b0);
        drain();
        begin
            wq_t exp;
            exp.push_back({32'h05050505, 4'hF, 1'b0});
            exp.push_back({32'h05050505, 4'hF, 1'b0});
            exp.push_back({32'h00000505, 4'h3, 1'b1});
            cmp_words("tail", q10, exp);
        end

        // Backpressure during a 10-neuron vector
        do_reset();
        mr = 1'b0;
        hold_viol = 0;
        for (int i = 0; i < 7; i++) send(rand_acc(), 1'($urandom_range(0, 1)));
        x = rand_acc();
        in_valid = 1'b1; in_data = x; relu_en = 1'b0;
        @(negedge clk);
        chk("bp.in_ready_drop", 32'(rdy10), 32'd0);
        repeat (20) @(posedge clk);
        #1 mr = 1'b1;
        @(negedge clk);
        chk("bp.in_ready_back", 32'(rdy10), 32'd1);
        bytes10.push_back(ref_q(x, 1'b0));
        @(posedge clk); #1 in_valid = 1'b0;
        send(rand_acc(), 1'b0);
        send(rand_acc(), 1'b1);
        drain();
        chk("bp.hold_stable", hold_viol, 32'd0);
        cmp_words("bp", q10, model_words(10, bytes10));

        // Back-to-back vectors at full rate
        do_reset();
        for (int i = 0; i < 30; i++) send(rand_acc(), 1'($urandom_range(0, 1)));
        drain();
        cmp_words("b2b", q10, model_words(10, bytes10));
        if (q10.size() == 9) begin
            chk("b2b.last3", 32'(q10[2].l), 32'd1);
            chk("b2b.last6", 32'(q10[5].l), 32'd1);
            chk("b2b.last9", 32'(q10[8].l), 32'd1);
        end
        chk("b2b.n1_words", nv1, 32'd30);
        chk("b2b.n1_no_bubble", last1 - first1 + 1, 32'd30);

        // Random downstream ready
        do_reset();
        hold_viol = 0;
        rnd_mr = 1;
        for (int i = 0; i < 20; i++) send(rand_acc(), 1'($urandom_range(0, 1)));
        @(posedge clk); #2;
        rnd_mr = 0; mr = 1'b1;
        drain();
        chk("rnd.hold_stable", hold_viol, 32'd0);
        cmp_words("rnd", q10, model_words(10, bytes10));

        // Mid-vector reset with a word pending
        do_reset();
        mr = 1'b0;
        for (int i = 0; i < 6; i++) send(rand_acc(), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.valid", 32'(v10), 32'd0);
        chk("mrst.data",  d10, 32'd0);
        chk("mrst.keep",  32'(k10), 32'd0);
        chk("mrst.last",  32'(l10), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mr = 1'b1;
        q10.delete(); bytes10.delete();
        for (int i = 0; i < 10; i++) send(rand_acc(), 1'($urandom_range(0, 1)));
        drain();
        cmp_words("mrst", q10, model_words(10, bytes10));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
